// File: rtl/hack_mem_arbiter_pkg.sv
// hack_mem_pkg: shared types and constants for the Hack RAM16K arbiter
// Contents: owner tags, arbiter state codes, default address/data widths.
package hack_mem_pkg;
  localparam int HACK_ADDR_W = 14;
  localparam int HACK_DATA_W = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_D} owner_e;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t S_IDLE   = 2'd0;
  localparam arb_state_t S_OWN_C  = 2'd1;
  localparam arb_state_t S_OWN_D  = 2'd2;
  localparam arb_state_t S_LOCK_D = 2'd3;
endpackage

// File: rtl/hack_mem_arbiter_if.sv
// hack_mem_arbiter_if: CPU (c_*), DMA (d_*) and RAM (mem_*) signal bundle
// slave: arbiter side (takes requests and mem_dout, drives grants/returns/RAM).
// master: requester/RAM side (the opposite directions).
interface hack_mem_arbiter_if import hack_mem_pkg::*; #(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W
);
  logic              c_req, c_we, c_gnt, c_rvalid, cpu_stall;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              d_req, d_lock, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din, mem_dout;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_lock, d_we, d_addr, d_wdata, mem_dout,
    output c_gnt, c_rvalid, c_rdata, cpu_stall, d_gnt, d_rvalid, d_rdata, mem_addr, mem_we, mem_din
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_lock, d_we, d_addr, d_wdata, mem_dout,
    input  c_gnt, c_rvalid, c_rdata, cpu_stall, d_gnt, d_rvalid, d_rdata, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/hack_mem_arbiter_rr_arb2.sv
// hack_rr_arb2: two-request round-robin grant generator with a locked burst for port D
// Ports: c_req_i/d_req_i requests, d_lock_i burst hold, c_gnt_o/d_gnt_o one-hot-or-zero grants.
module hack_rr_arb2 import hack_mem_pkg::*; #(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_req_i,
  input  logic d_req_i,
  input  logic d_lock_i,
  output logic c_gnt_o,
  output logic d_gnt_o
);
  arb_state_t state_q, state_d;
  owner_e     last_q, last_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       hold, at_max;
  always_comb begin
    hold    = state_q == S_LOCK_D && d_req_i && d_lock_i;
    at_max  = bcnt_q == 8'(MAX_BURST);
    // a held lock only yields once the burst budget is spent and C is actually waiting
    c_gnt_o = hold ? at_max && c_req_i : c_req_i && (!d_req_i || last_q == OWN_D);
    d_gnt_o = d_req_i && !c_gnt_o;
    state_d = c_gnt_o ? S_OWN_C : !d_gnt_o ? S_IDLE : d_lock_i ? S_LOCK_D : S_OWN_D;
    last_d  = c_gnt_o ? OWN_C : d_gnt_o ? OWN_D : last_q;
    bcnt_d  = !(d_gnt_o && d_lock_i) ? 8'd0 : !hold ? 8'd1 : at_max ? bcnt_q : bcnt_q + 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= OWN_D;
      bcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
endmodule

// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter: shares one RAM16K port between the Hack CPU (C) and a DMA engine (D)
// Ports: clk, rst_n (async active-low), bus (slave modport: requests, grants, read returns, RAM).
// Accesses issue to registered mem_* one cycle after grant; reads return two cycles after grant.
module hack_mem_arbiter import hack_mem_pkg::*; #(
  parameter int ADDR_W    = HACK_ADDR_W,
  parameter int DATA_W    = HACK_DATA_W,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst_n,
  hack_mem_arbiter_if.slave bus
);
  logic              c_gnt, d_gnt, c_rv, d_rv;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  owner_e            p1_q, p1_d, p2_q;
  hack_rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk(clk), .rst_n(rst_n),
    .c_req_i(bus.c_req), .d_req_i(bus.d_req), .d_lock_i(bus.d_lock),
    .c_gnt_o(c_gnt), .d_gnt_o(d_gnt)
  );
  always_comb begin
    we_d   = c_gnt ? bus.c_we : d_gnt && bus.d_we;
    addr_d = c_gnt ? bus.c_addr : d_gnt ? bus.d_addr : addr_q;
    din_d  = c_gnt ? bus.c_wdata : d_gnt ? bus.d_wdata : din_q;
    // owner tag doubles as the valid bit: OWN_NONE means no read in this stage
    p1_d   = c_gnt && !bus.c_we ? OWN_C : d_gnt && !bus.d_we ? OWN_D : OWN_NONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      p1_q   <= OWN_NONE;
      p2_q   <= OWN_NONE;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      p1_q   <= p1_d;
      p2_q   <= p1_q;
    end
  assign c_rv          = p2_q == OWN_C;
  assign d_rv          = p2_q == OWN_D;
  assign bus.c_gnt     = c_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.cpu_stall = bus.c_req && !c_gnt;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
  assign bus.c_rvalid  = c_rv;
  assign bus.d_rvalid  = d_rv;
  assign bus.c_rdata   = c_rv ? bus.mem_dout : '0;
  assign bus.d_rdata   = d_rv ? bus.mem_dout : '0;
endmodule
